seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_mul_pkg.sv | 12 +
 rtl/twos_negate.sv | 12 +
 rtl/seq_multiplier.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement: passes x_i through, or negates it when neg_i is set.
module twos_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, signed or unsigned, one multiplier bit per cycle.
// Magnitudes are multiplied unsigned; the sign is applied once when the product is registered.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p_hi,
    output logic [WIDTH-1:0] p_lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;

    state_e state_q, state_d;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] p_hi_q, p_lo_q;
    logic             busy_q, done_q;

    logic             load_c, step_c, finish_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [PW-1:0]    prod_c;

    twos_negate #(.W(WIDTH)) u_mag_a (
        .x_i   (a),
        .neg_i (signed_mode & a[WIDTH-1]),
        .y_o   (a_mag_c)
    );

    twos_negate #(.W(WIDTH)) u_mag_b (
        .x_i   (b),
        .neg_i (signed_mode & b[WIDTH-1]),
        .y_o   (b_mag_c)
    );

    // Sign fix sees the post-step value so the final step and result capture share one edge.
    twos_negate #(.W(PW)) u_sign_p (
        .x_i   ({acc_d, mplier_d}),
        .neg_i (neg_q),
        .y_o   (prod_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (cnt_q == WIDTH'(1)) begin
                    finish_c = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        sum_c    = '0;
        if (load_c) begin
            mcand_d  = a_mag_c;
            mplier_d = b_mag_c;
            acc_d    = '0;
            cnt_d    = WIDTH'(WIDTH);
            neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step_c) begin
            // Carry out of the add becomes the new MSB of the shifted {acc, mplier} pair.
            sum_c    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
            acc_d    = sum_c[WIDTH:1];
            mplier_d = {sum_c[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
            if (finish_c) begin
                p_hi_q <= prod_c[PW-1:WIDTH];
                p_lo_q <= prod_c[WIDTH-1:0];
            end
        end
    end

    assign p_hi = p_hi_q;
    assign p_lo = p_lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
